// File: rtl/apb_pkg.sv
// apb_pkg: shared state encodings, default widths and counter sizing for the APB requester
package apb_pkg;

    localparam int APB_ADDR_WIDTH     = 32;
    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_TIMEOUT_CYCLES = 16;

    localparam logic [1:0] APB_IDLE   = 2'b00;
    localparam logic [1:0] APB_SETUP  = 2'b01;
    localparam logic [1:0] APB_ACCESS = 2'b10;
    localparam logic [1:0] APB_RESP   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = APB_IDLE,
        ST_SETUP  = APB_SETUP,
        ST_ACCESS = APB_ACCESS,
        ST_RESP   = APB_RESP
    } apb_m_state_t;

    // Counter wide enough to hold the threshold itself; never narrower than one bit.
    function automatic int ctr_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: saturating wait-state counter that flags when the timeout threshold is reached
module apb_timeout_ctr
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clr,
    input  logic en,
    input  logic sat,
    output logic hit
);

    localparam int W = ctr_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] MAX   = '1;

    logic [W-1:0] cnt;
    logic         at_top;

    // With sat high the count parks at the threshold; otherwise it parks at all-ones. It never wraps.
    assign at_top = sat ? (cnt == LIMIT) : (cnt == MAX);
    // A zero threshold disables the timeout entirely.
    assign hit = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

    // Count enabled cycles until the parking value, clear has priority.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !at_top)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/apb_m_if.sv
// apb_m_if: single-outstanding command/response to APB requester with bounded wait-state timeout
module apb_m_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    apb_m_state_t state, state_nx;
    logic         hit;
    logic         in_access;

    assign in_access = (state == ST_ACCESS);
    assign cmd_ready = (state == ST_IDLE);

    apb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ctr (
        .pclk   (pclk),
        .presetn(presetn),
        .clr    (state == ST_SETUP),
        .en     (in_access && !pready),
        .sat    (1'b1),
        .hit    (hit)
    );

    // Next-state decode; pready is checked before the timeout so a late completer still wins.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = cmd_valid ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_nx = ST_ACCESS;
            ST_ACCESS: state_nx = (pready || hit) ? ST_RESP : ST_ACCESS;
            ST_RESP:   state_nx = rsp_ready ? ST_IDLE : ST_RESP;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // State and bus strobes are registered from the next state so the APB side is glitch-free.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= ST_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            psel      <= (state_nx == ST_SETUP) || (state_nx == ST_ACCESS);
            penable   <= (state_nx == ST_ACCESS);
            rsp_valid <= (state_nx == ST_RESP);
        end
    end

    // Request fields are latched once at acceptance and held for the whole transfer.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
        end else if (cmd_ready && cmd_valid) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_write ? cmd_wdata : '0;
        end
    end

    // Response is captured on leaving ACCESS and held until the next transfer completes.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (in_access && pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
        end else if (in_access && hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_m_if.sv
// tb_apb_m_if: directed checks of the APB requester against hand-computed transfer outcomes
module tb_apb_m_if;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready, pslverr;

    int    n_cmp = 0;
    int    n_bad = 0;
    string tname = "reset";

    apb_m_if #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h expected %0h", tname, tag, obs, exp);
        end
    endtask

    // Issue one command and walk it cycle by cycle to the response; pready rises in ACCESS cycle 'waits'.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic slverr,
                        input int lat, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_tmo);
        logic [31:0] exp_pwdata;
        exp_pwdata = wr ? wdata : 32'h0;
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_addr   = addr;
        cmd_wdata  = wdata;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge pclk);
        for (int c = 1; c <= lat; c++) begin
            @(negedge pclk);
            if (c == 1) begin
                cmd_valid = 1'b0;
                cmd_addr  = '1;
                cmd_wdata = '1;
                check("setup_psel", psel, 1);
                check("setup_penable", penable, 0);
                check("setup_cmd_ready", cmd_ready, 0);
            end else if (c < lat) begin
                check("access_psel", psel, 1);
                check("access_penable", penable, 1);
            end
            if (c < lat) begin
                check("busy_rsp_valid", rsp_valid, 0);
                check("paddr", paddr, addr);
                check("pwdata", pwdata, exp_pwdata);
                check("pwrite", pwrite, wr);
                pready  = (c == 1) ? (waits == 0) : (c - 2 == waits);
                prdata  = pready ? rdata : (32'hBAD0_0000 | c);
                pslverr = pready ? slverr : 1'b1;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                check("rsp_valid", rsp_valid, 1);
                check("resp_psel", psel, 0);
                check("resp_penable", penable, 0);
                check("resp_cmd_ready", cmd_ready, 0);
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", rsp_err, exp_err);
                check("rsp_timeout", rsp_timeout, exp_tmo);
            end
        end
    endtask

    // Hold the response for 'hold' more cycles, then accept it and confirm return to IDLE.
    task automatic consume(input int hold, input logic [31:0] exp_rdata, input logic exp_err,
                           input logic exp_tmo);
        for (int i = 0; i < hold; i++) begin
            @(negedge pclk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_rdata", rsp_rdata, exp_rdata);
            check("hold_rsp_err", rsp_err, exp_err);
            check("hold_rsp_timeout", rsp_timeout, exp_tmo);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_psel", psel, 0);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_psel", psel, 0);
    endtask

    task automatic check_reset_values();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
    endtask

    initial begin
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (3) @(negedge pclk);
        check_reset_values();
        presetn = 1'b1;
        @(negedge pclk);
        check_reset_values();

        tname = "wr_zero_wait";
        xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 1'b0, 3, 32'h0, 1'b0, 1'b0);
        consume(0, 32'h0, 1'b0, 1'b0);

        tname = "rd_3_waits";
        xfer(1'b0, 32'h0000_0020, 32'h0, 3, 32'h1234_5678, 1'b0, 6, 32'h1234_5678, 1'b0, 1'b0);
        consume(0, 32'h1234_5678, 1'b0, 1'b0);

        tname = "rd_slverr";
        rsp_ready = 1'b1;
        xfer(1'b0, 32'h0000_0030, 32'h0, 0, 32'hCAFE_0001, 1'b1, 3, 32'hCAFE_0001, 1'b1, 1'b0);
        consume(0, 32'hCAFE_0001, 1'b1, 1'b0);

        tname = "rd_timeout";
        xfer(1'b0, 32'h0000_0040, 32'h0, 99, 32'h0, 1'b0, 7, 32'h0, 1'b1, 1'b1);
        consume(1, 32'h0, 1'b1, 1'b1);

        tname = "rd_ready_4th";
        xfer(1'b0, 32'h0000_0044, 32'h0, 3, 32'hA5A5_0004, 1'b0, 6, 32'hA5A5_0004, 1'b0, 1'b0);
        consume(0, 32'hA5A5_0004, 1'b0, 1'b0);

        tname = "rd_ready_at_limit";
        xfer(1'b0, 32'h0000_0048, 32'h0, 4, 32'h5A5A_0005, 1'b0, 7, 32'h5A5A_0005, 1'b0, 1'b0);
        consume(0, 32'h5A5A_0005, 1'b0, 1'b0);

        tname = "backpressure";
        xfer(1'b1, 32'h0000_0050, 32'h0BAD_F00D, 1, 32'h1111_1111, 1'b0, 4, 32'h0, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0060;
        consume(5, 32'h0, 1'b0, 1'b0);
        tname = "back_to_back";
        xfer(1'b0, 32'h0000_0060, 32'h0, 0, 32'h600D_600D, 1'b0, 3, 32'h600D_600D, 1'b0, 1'b0);
        consume(0, 32'h600D_600D, 1'b0, 1'b0);

        tname = "reset_mid_xfer";
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0070;
        pready    = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("pre_rst_penable", penable, 1);
        #2 presetn = 1'b0;
        #1;
        check("async_psel", psel, 0);
        check("async_penable", penable, 0);
        check("async_rsp_valid", rsp_valid, 0);
        check("async_cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        presetn = 1'b1;
        pready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check("post_rst_cmd_ready", cmd_ready, 1);
            check("post_rst_rsp_valid", rsp_valid, 0);
            check("post_rst_psel", psel, 0);
        end

        tname = "wr_after_reset";
        xfer(1'b1, 32'h0000_0080, 32'h8080_8080, 0, 32'h0, 1'b0, 3, 32'h0, 1'b0, 1'b0);
        consume(0, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_m_if.md
# apb_m_if

APB requester (master) that turns a single-outstanding command/response handshake into APB SETUP/ACCESS transfers toward the APB completer interface on the same bus. It sits between an internal bus agent and the peripheral fabric. It registers address, data and direction at command acceptance, waits on `pready` with a bounded timeout, and returns read data and error status on a held response channel.

## Interface
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width.
- `TIMEOUT_CYCLES`, 16: number of consecutive ACCESS cycles with `pready` low before abort. A value of 0 disables the timeout.

- `pclk` in 1: the single clock.
- `presetn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: transfer address.
- `cmd_wdata` in DATA_WIDTH: write data.
- `rsp_valid` out 1: response available; held until `rsp_ready`.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes and timeouts.
- `rsp_err` out 1: `pslverr` was seen, or a timeout occurred.
- `rsp_timeout` out 1: transfer was aborted by the timeout.
- `paddr` out ADDR_WIDTH, `pwdata` out DATA_WIDTH, `pwrite` out 1, `psel` out 1, `penable` out 1: APB request.
- `prdata` in DATA_WIDTH, `pready` in 1, `pslverr` in 1: APB completion.

## Operation
States are encoded in 2 bits:
- IDLE = 00
- SETUP = 01
- ACCESS = 10
- RESP = 11

State transitions and actions:
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid`, register `paddr`/`pwrite` and go to SETUP.
  - `pwdata` is registered as `cmd_wdata` for writes, 0 for reads.
- **SETUP**
  - `psel` = 1, `penable` = 0.
  - Always go to ACCESS next cycle.
  - Clear the timeout counter.
- **ACCESS**
  - `psel` = 1, `penable` = 1.
  - `paddr`, `pwrite` and `pwdata` stay stable for the whole state.
  - `pready` = 1: capture `rsp_rdata` (= `prdata` if read, else 0) and `rsp_err` = `pslverr`; go to RESP.
  - `pready` = 0: increment the counter. When the counter reaches `TIMEOUT_CYCLES`, go to RESP with `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - `pready` high on the same cycle as the timeout threshold: `pready` wins (normal completion).
- **RESP**
  - `psel` = 0, `penable` = 0, `rsp_valid` = 1.
  - On `rsp_ready`, go to IDLE.
  - `rsp_*` values are held stable until consumed.
- `pslverr` is sampled only in ACCESS when `pready` = 1; it is ignored otherwise.
- Undefined state encoding: not reachable (the 2-bit encoding is full); the default branch goes to IDLE.
- Reset asserted mid-transfer: `psel`/`penable` drop immediately (asynchronously). The pending response is discarded and is not replayed.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` with a minimum of 1; it saturates and never wraps.

## Timing
- Reset values:
  - All outputs are 0 except `cmd_ready`.
  - `cmd_ready` = 1 (reset enters IDLE).
  - `paddr`, `pwdata`, `rsp_rdata` = 0.
- Command accepted at edge N:
  - SETUP is visible in cycle N+1.
  - ACCESS is visible from cycle N+2.
- Zero-wait completer (`pready` high in the first ACCESS cycle): `rsp_valid` rises at N+3.
- Each wait state adds one cycle.
- Timeout: with `pready` stuck low, `rsp_valid` rises at N+3+`TIMEOUT_CYCLES`.
- `rsp_ready` already high when `rsp_valid` rises: IDLE in the next cycle, and the next command can be accepted one cycle later.
- Minimum cadence is 4 cycles per transfer.
- Exactly one transfer is outstanding at a time. `cmd_ready` is 0 in SETUP, ACCESS and RESP.
- All APB outputs are driven from registers; there is no combinational path from `cmd_*` to `p*`.

## Structure
- Shared package `apb_pkg` holds:
  - `apb_m_state_t`: enum with the four encodings above.
  - Localparams `APB_IDLE`, `APB_SETUP`, `APB_ACCESS`, `APB_RESP`.
  - The default width constants.
- One sub-module, `apb_timeout_ctr`. It has clear, enable and saturate controls and a `hit` output, and is parameterised by `TIMEOUT_CYCLES`. The counter only.

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF, `pready` tied 1:
  - `psel` rises at N+1 and `penable` at N+2.
  - `pwdata` = 0xDEAD_BEEF and `pwrite` = 1 are stable throughout.
  - `rsp_valid` at N+3 with `rsp_err` = 0 and `rsp_rdata` = 0.
- Read 0x0000_0020 with 3 wait states, `prdata` = 0x1234_5678 on the `pready` cycle:
  - `rsp_valid` at N+6.
  - `rsp_rdata` = 0x1234_5678.
  - `paddr` is constant for all ACCESS cycles.
- Read with `pslverr` = 1 alongside `pready`: `rsp_err` = 1, `rsp_timeout` = 0.
- `TIMEOUT_CYCLES` = 4, `pready` stuck low:
  - Abort after 4 ACCESS cycles.
  - `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - `psel` is 0 in RESP.
  - Repeat with `pready` rising on the 4th cycle: normal completion.
- Response backpressure and back-to-back commands:
  - Hold `rsp_ready` = 0 for 5 cycles: `rsp_*` stay stable and `cmd_ready` stays 0.
  - Release `rsp_ready`, with `cmd_valid` held high: the second command is accepted at exactly 1 cycle after the response handshake.
- Reset mid-transfer: assert `presetn` = 0 during ACCESS:
  - `psel`/`penable`/`rsp_valid` go to 0 asynchronously.
  - After release, `cmd_ready` = 1 and no stale response appears.
